// File: rtl/pat_seq_ctrl.sv
// Slot-table pattern sequencer: slot 0 appears 1 cycle after start, a valid slot holds until i_ready, gaps take 1 cycle.
// Optional PAT_SEQ_STAT_EN adds o_frame_cnt, a 16-bit count of completed passes over slot i_len.
module pat_seq_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          sclk,
    input  logic          rst_n,
    input  logic          i_cfg_we,
    input  logic [AW-1:0] i_cfg_addr,
    input  logic [DW-1:0] i_cfg_data,
    input  logic          i_cfg_vld,
    input  logic [AW-1:0] i_len,
    input  logic          i_loop,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_ready,
    output logic          o_dv,
    output logic [DW-1:0] o_data,
    output logic          o_busy,
    output logic          o_done
`ifdef PAT_SEQ_STAT_EN
    ,
    output logic [15:0]   o_frame_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q;
    logic          busy_q;
    logic          dv_q;
    logic [DW-1:0] data_q;
    logic          done_q;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] len_q;
    logic          loop_q;
    logic          stop_pend_q;
    logic          tbl_vld_q [DEPTH];
    logic [DW-1:0] tbl_dat_q [DEPTH];
`ifdef PAT_SEQ_STAT_EN
    logic [15:0]   frame_cnt_q;
`endif

    logic [AW-1:0] cur_idx;
    logic          at_last;
    logic          slot_done;
    logic          stop_req;
    logic          finish;
    logic [AW-1:0] ld_idx;
    logic          ld_vld;
    logic [DW-1:0] ld_dat;

    // ptr_q always points one past the slot on the output registers.
    assign cur_idx   = ptr_q - AW'(1);
    assign at_last   = (cur_idx == len_q);
    assign slot_done = !dv_q || i_ready;
    assign stop_req  = stop_pend_q || i_stop;
    assign finish    = stop_req || (at_last && !loop_q);
    assign ld_idx    = (state_q == RUN && !at_last) ? ptr_q : '0;
    assign ld_vld    = tbl_vld_q[ld_idx];
    assign ld_dat    = ld_vld ? tbl_dat_q[ld_idx] : '0;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            dv_q        <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            ptr_q       <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_vld_q[i] <= 1'b0;
                tbl_dat_q[i] <= '0;
            end
`ifdef PAT_SEQ_STAT_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Slot 0 load reads the table before this edge's write lands.
                    if (i_cfg_we) begin
                        tbl_vld_q[i_cfg_addr] <= i_cfg_vld;
                        tbl_dat_q[i_cfg_addr] <= i_cfg_data;
                    end
                    if (i_start && !i_stop) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        len_q       <= i_len;
                        loop_q      <= i_loop;
                        stop_pend_q <= 1'b0;
                        dv_q        <= ld_vld;
                        data_q      <= ld_dat;
                        ptr_q       <= AW'(1);
`ifdef PAT_SEQ_STAT_EN
                        frame_cnt_q <= '0;
`endif
                    end
                end
                RUN: begin
                    stop_pend_q <= stop_req;
                    if (slot_done) begin
`ifdef PAT_SEQ_STAT_EN
                        if (at_last) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end
`endif
                        if (finish) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            dv_q        <= 1'b0;
                            data_q      <= '0;
                            done_q      <= 1'b1;
                            stop_pend_q <= 1'b0;
                        end else begin
                            dv_q   <= ld_vld;
                            data_q <= ld_dat;
                            ptr_q  <= at_last ? AW'(1) : ptr_q + AW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign o_dv   = dv_q;
    assign o_data = data_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
`ifdef PAT_SEQ_STAT_EN
    assign o_frame_cnt = frame_cnt_q;
`endif

endmodule
